// File: rtl/sevseg_pkg.sv
// Shared constants and the BCD-to-segment decoder for the seven-segment counter.
package sevseg_pkg;

  localparam int MAX_DIGITS = 8;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd2seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Divides the clock into a registered one-cycle enable pulse every DIV cycles;
// the first pulse is visible in the DIV-th cycle after reset release.
module clk_enable_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CW'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      tick <= (cnt == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/seven_seg_mux_counter.sv
// N-digit BCD up/down counter with multiplexed common-anode seven-segment scan.
// Define SEVSEG_LZB_EN to blank leading zeros on digits above digit 0.
module seven_seg_mux_counter
  import sevseg_pkg::*;
#(
  parameter int BOARD_FREQ = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_HZ    = 1000,
  parameter int DIGITS     = 4
) (
  input  logic                  Clk,
  input  logic                  Clr_n,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Load_val,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Wrap,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     an
);

  localparam int TICK_DIV = BOARD_FREQ / TICK_HZ;
  localparam int SCAN_DIV = BOARD_FREQ / SCAN_HZ;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_digits_range
    $error("DIGITS out of range");
  end

  logic              count_tick;
  logic              scan_tick;
  logic [4*DIGITS-1:0] load_clean;
  logic [4*DIGITS-1:0] count_next;
  logic              count_wrap;
  logic [3:0]        digit;
  logic              carry;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  scan_next;
  logic              scan_started;
  logic [6:0]        seg_digit [DIGITS];

  clk_enable_div #(.DIV(TICK_DIV)) u_count_div (
    .clk   (Clk),
    .rst_n (Clr_n),
    .tick  (count_tick)
  );

  clk_enable_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (Clk),
    .rst_n (Clr_n),
    .tick  (scan_tick)
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] val;
    assign val = Bcd[4*gi +: 4];
    assign load_clean[4*gi +: 4] = (Load_val[4*gi +: 4] > 4'd9) ? 4'd0 : Load_val[4*gi +: 4];
`ifdef SEVSEG_LZB_EN
    if (gi > 0) begin : g_lzb
      assign seg_digit[gi] = (Bcd[4*DIGITS-1:4*gi] == '0) ? SEG_BLANK : bcd2seg(val);
    end else begin : g_lsd
      assign seg_digit[gi] = bcd2seg(val);
    end
`else
    assign seg_digit[gi] = bcd2seg(val);
`endif
  end

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    count_next = Bcd;
    carry      = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = Bcd[4*i +: 4];
      if (carry) begin
        if (Up) begin
          if (digit == 4'd9) digit = 4'd0;
          else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) digit = 4'd9;
          else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      count_next[4*i +: 4] = digit;
    end
    count_wrap = carry;
  end

  // The very first scan tick lands on digit 0 instead of advancing past it.
  always_comb begin
    if (!scan_started)                        scan_next = '0;
    else if (scan_idx == IDX_W'(DIGITS - 1))  scan_next = '0;
    else                                      scan_next = scan_idx + 1'b1;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      Bcd          <= '0;
      Wrap         <= 1'b0;
      Seg          <= SEG_BLANK;
      an           <= '1;
      scan_idx     <= '0;
      scan_started <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      if (Load) begin
        Bcd <= load_clean;
      end else if (count_tick && En) begin
        Bcd  <= count_next;
        Wrap <= count_wrap;
      end
      if (scan_tick) begin
        scan_idx     <= scan_next;
        scan_started <= 1'b1;
        an           <= ~(DIGITS'(1) << scan_next);
        Seg          <= seg_digit[scan_next];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_counter.sv
// Directed bench for seven_seg_mux_counter (TICK_DIV=10, SCAN_DIV=2, two digits).
module tb_seven_seg_mux_counter;

  logic       Clk;
  logic       Clr_n;
  logic       En;
  logic       Up;
  logic       Load;
  logic [7:0] Load_val;
  logic [7:0] Bcd;
  logic       Wrap;
  logic [6:0] Seg;
  logic [1:0] an;

  int total = 0;
  int bad   = 0;
  int edges = 0;

`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] EXP_LEAD_ZERO = 7'h7F;
`else
  localparam logic [6:0] EXP_LEAD_ZERO = 7'h40;
`endif

  seven_seg_mux_counter #(
    .BOARD_FREQ (100),
    .TICK_HZ    (10),
    .SCAN_HZ    (50),
    .DIGITS     (2)
  ) dut (
    .Clk      (Clk),
    .Clr_n    (Clr_n),
    .En       (En),
    .Up       (Up),
    .Load     (Load),
    .Load_val (Load_val),
    .Bcd      (Bcd),
    .Wrap     (Wrap),
    .Seg      (Seg),
    .an       (an)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Clock edges since reset release: count ticks apply on multiples of 10,
  // scan updates land on even edges starting at edge 2 (digit 0 first).
  always @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (edges < n && guard < 2000) begin
      @(negedge Clk);
      guard++;
    end
    if (edges != n) begin
      total++; bad++;
      $display("FAIL go_to edges=%0d wanted=%0d", edges, n);
    end
  endtask

  task automatic do_load(input logic [7:0] val, input int at_edge);
    go_to(at_edge - 1);
    Load_val = val;
    Load = 1'b1;
    go_to(at_edge);
    Load = 1'b0;
  endtask

  task automatic test_reset;
    Clr_n = 1'b0; En = 1'b1; Up = 1'b1; Load = 1'b0; Load_val = 8'h00;
    @(negedge Clk); @(negedge Clk);
    total++; if (Bcd !== 8'h00) begin bad++; $display("FAIL rst_bcd got=%h exp=00", Bcd); end
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL rst_wrap got=%b exp=0", Wrap); end
    total++; if (Seg !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7f", Seg); end
    total++; if (an !== 2'b11) begin bad++; $display("FAIL rst_an got=%b exp=11", an); end
    Clr_n = 1'b1;
  endtask

  task automatic test_count_up;
    go_to(1);
    total++; if (an !== 2'b11) begin bad++; $display("FAIL up_an_e1 got=%b exp=11", an); end
    go_to(2);
    total++; if (an !== 2'b10) begin bad++; $display("FAIL up_an_e2 got=%b exp=10", an); end
    total++; if (Seg !== 7'h40) begin bad++; $display("FAIL up_seg_e2 got=%h exp=40", Seg); end
    go_to(4);
    total++; if (an !== 2'b01) begin bad++; $display("FAIL up_an_e4 got=%b exp=01", an); end
    total++; if (Seg !== EXP_LEAD_ZERO) begin bad++; $display("FAIL up_seg_e4 got=%h exp=%h", Seg, EXP_LEAD_ZERO); end
    go_to(9);
    total++; if (Bcd !== 8'h00) begin bad++; $display("FAIL up_e9 got=%h exp=00", Bcd); end
    go_to(10);
    total++; if (Bcd !== 8'h01) begin bad++; $display("FAIL up_e10 got=%h exp=01", Bcd); end
    go_to(19);
    total++; if (Bcd !== 8'h01) begin bad++; $display("FAIL up_e19 got=%h exp=01", Bcd); end
    go_to(20);
    total++; if (Bcd !== 8'h02) begin bad++; $display("FAIL up_e20 got=%h exp=02", Bcd); end
  endtask

  task automatic test_wrap_up;
    do_load(8'h98, 21);
    total++; if (Bcd !== 8'h98) begin bad++; $display("FAIL wrapup_load got=%h exp=98", Bcd); end
    go_to(30);
    total++; if (Bcd !== 8'h99 || Wrap !== 1'b0) begin bad++; $display("FAIL wrapup_99 got=%h/%b exp=99/0", Bcd, Wrap); end
    go_to(40);
    total++; if (Bcd !== 8'h00 || Wrap !== 1'b1) begin bad++; $display("FAIL wrapup_00 got=%h/%b exp=00/1", Bcd, Wrap); end
    go_to(41);
    total++; if (Bcd !== 8'h00 || Wrap !== 1'b0) begin bad++; $display("FAIL wrapup_after got=%h/%b exp=00/0", Bcd, Wrap); end
  endtask

  task automatic test_down;
    Up = 1'b0;
    do_load(8'h00, 42);
    total++; if (Bcd !== 8'h00) begin bad++; $display("FAIL down_load got=%h exp=00", Bcd); end
    go_to(50);
    total++; if (Bcd !== 8'h99 || Wrap !== 1'b1) begin bad++; $display("FAIL down_99 got=%h/%b exp=99/1", Bcd, Wrap); end
    go_to(51);
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL down_wrap_clr got=%b exp=0", Wrap); end
    go_to(60);
    total++; if (Bcd !== 8'h98) begin bad++; $display("FAIL down_98 got=%h exp=98", Bcd); end
    do_load(8'h40, 61);
    go_to(70);
    total++; if (Bcd !== 8'h39 || Wrap !== 1'b0) begin bad++; $display("FAIL down_borrow got=%h/%b exp=39/0", Bcd, Wrap); end
    do_load(8'hA5, 71);
    total++; if (Bcd !== 8'h05) begin bad++; $display("FAIL load_clamp_hi got=%h exp=05", Bcd); end
    do_load(8'hC3, 72);
    total++; if (Bcd !== 8'h03) begin bad++; $display("FAIL load_clamp_c3 got=%h exp=03", Bcd); end
  endtask

  task automatic test_load_vs_tick;
    Up = 1'b1;
    do_load(8'h42, 80);
    total++; if (Bcd !== 8'h42) begin bad++; $display("FAIL ldtick_e80 got=%h exp=42", Bcd); end
    go_to(81);
    total++; if (Bcd !== 8'h42) begin bad++; $display("FAIL ldtick_e81 got=%h exp=42", Bcd); end
    go_to(90);
    total++; if (Bcd !== 8'h43) begin bad++; $display("FAIL ldtick_e90 got=%h exp=43", Bcd); end
    go_to(95);
    En = 1'b0;
    go_to(100);
    total++; if (Bcd !== 8'h43) begin bad++; $display("FAIL en_off got=%h exp=43", Bcd); end
    go_to(101);
    En = 1'b1;
    go_to(110);
    total++; if (Bcd !== 8'h44) begin bad++; $display("FAIL en_noqueue got=%h exp=44", Bcd); end
  endtask

  task automatic test_scan;
    do_load(8'h37, 111);
    go_to(112);
    total++; if (an !== 2'b01 || Seg !== 7'h30) begin bad++; $display("FAIL scan_e112 got=%b/%h exp=01/30", an, Seg); end
    go_to(113);
    total++; if (an !== 2'b01 || Seg !== 7'h30) begin bad++; $display("FAIL scan_e113 got=%b/%h exp=01/30", an, Seg); end
    go_to(114);
    total++; if (an !== 2'b10 || Seg !== 7'h78) begin bad++; $display("FAIL scan_e114 got=%b/%h exp=10/78", an, Seg); end
    go_to(116);
    total++; if (an !== 2'b01 || Seg !== 7'h30) begin bad++; $display("FAIL scan_e116 got=%b/%h exp=01/30", an, Seg); end
    do_load(8'h05, 117);
    go_to(118);
    total++; if (an !== 2'b10 || Seg !== 7'h12) begin bad++; $display("FAIL scan_e118 got=%b/%h exp=10/12", an, Seg); end
    go_to(120);
    total++; if (an !== 2'b01 || Seg !== EXP_LEAD_ZERO) begin bad++; $display("FAIL scan_lead got=%b/%h exp=01/%h", an, Seg, EXP_LEAD_ZERO); end
    total++; if (Bcd !== 8'h06) begin bad++; $display("FAIL scan_bcd got=%h exp=06", Bcd); end
  endtask

  task automatic test_reset_mid;
    go_to(121);
    #2 Clr_n = 1'b0;
    #1;
    total++; if (Bcd !== 8'h00 || Wrap !== 1'b0) begin bad++; $display("FAIL midrst_bcd got=%h/%b exp=00/0", Bcd, Wrap); end
    total++; if (Seg !== 7'h7F || an !== 2'b11) begin bad++; $display("FAIL midrst_disp got=%h/%b exp=7f/11", Seg, an); end
    @(negedge Clk);
    Clr_n = 1'b1;
    go_to(1);
    total++; if (an !== 2'b11) begin bad++; $display("FAIL midrst_e1 got=%b exp=11", an); end
    go_to(2);
    total++; if (an !== 2'b10 || Seg !== 7'h40) begin bad++; $display("FAIL midrst_e2 got=%b/%h exp=10/40", an, Seg); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap_up;
    test_down;
    test_load_vs_tick;
    test_scan;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
